// File: rtl/tensil_mem_pkg.sv
// Shared types and default sizing for the local-memory BRAM port sequencer.
package tensil_mem_pkg;

    localparam int DEF_DATA_W    = 128;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_LEN_W     = 8;
    localparam int DEF_RSP_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } rsp_beat_t;

endpackage

// File: rtl/bram_seq_rsp_fifo.sv
// Synchronous response FIFO (DEPTH entries, registered occupancy) that buffers
// BRAM read beats until the consumer accepts them. DEPTH must be a power of 2.
module bram_seq_rsp_fifo
    import tensil_mem_pkg::*;
#(
    parameter int DEPTH = DEF_RSP_DEPTH,
    parameter int WIDTH = DEF_DATA_W + 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;

    // Pop of an empty FIFO is ignored; the credit scheme guarantees push never overflows.
    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // NOTE: storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_port_sequencer.sv
// Burst front end for one BRAM port: sequential addressing, credit-limited reads,
// buffered responses. Define BRAM_SEQ_STATS_EN to add read/write beat counters.
module bram_port_sequencer
    import tensil_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [LEN_W-1:0]  i_req_len,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_last,
    output logic              o_busy,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_di,
    input  logic [DATA_W-1:0] i_mem_do
`ifdef BRAM_SEQ_STATS_EN
    ,
    output logic [31:0]       o_stat_rd_beats,
    output logic [31:0]       o_stat_wr_beats
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_accept;
    logic              w_issue_wr;
    logic              w_issue_rd;
    logic              w_at_last;
    logic [CNT_W-1:0]  w_occ;
    logic [CNT_W-1:0]  w_outstanding;
    logic [DATA_W:0]   w_fifo_rdata;

    // Credit is built only from registers, so rsp_ready never reaches mem_en combinationally.
    assign w_outstanding = CNT_W'(r_inflight) + w_occ;
    assign w_at_last     = (r_cnt == r_len);
    assign w_accept      = o_req_ready && i_req_valid;

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        w_issue_wr  = 1'b0;
        w_issue_rd  = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                if (r_write) begin
                    w_issue_wr = i_wr_valid;
                end else begin
                    w_issue_rd = (w_outstanding < CNT_W'(RSP_DEPTH));
                end
                if ((w_issue_wr || w_issue_rd) && w_at_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_mem_en   = w_issue_wr || w_issue_rd;
    assign o_mem_we   = w_issue_wr;
    assign o_wr_ready = w_issue_wr;
    assign o_mem_addr = r_addr;
    assign o_mem_di   = i_wr_data;
    assign o_busy     = (r_state == BURST) || (w_outstanding != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_write         <= 1'b0;
            r_addr          <= '0;
            r_len           <= '0;
            r_cnt           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_write <= i_req_write;
                r_addr  <= i_req_addr;
                r_len   <= i_req_len;
                r_cnt   <= '0;
            end else if (o_mem_en) begin
                // Address wraps modulo the BRAM depth by natural overflow.
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt + LEN_W'(1);
            end
            r_inflight      <= w_issue_rd;
            r_inflight_last <= w_issue_rd && w_at_last;
        end
    end

    bram_seq_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (r_inflight),
        .i_wdata ({i_mem_do, r_inflight_last}),
        .i_pop   (i_rsp_ready),
        .o_rdata (w_fifo_rdata),
        .o_count (w_occ)
    );

    assign o_rsp_valid = (w_occ != '0);
    assign o_rsp_data  = w_fifo_rdata[DATA_W:1];
    assign o_rsp_last  = o_rsp_valid && w_fifo_rdata[0];

`ifdef BRAM_SEQ_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (w_issue_rd) begin
                r_stat_rd <= r_stat_rd + 32'd1;
            end
            if (w_issue_wr) begin
                r_stat_wr <= r_stat_wr + 32'd1;
            end
        end
    end

    assign o_stat_rd_beats = r_stat_rd;
    assign o_stat_wr_beats = r_stat_wr;
`endif

endmodule

// File: tb/tb_bram_port_sequencer.sv
// Directed bench for bram_port_sequencer with a behavioural 64x128 BRAM behind the port.
module tb_bram_port_sequencer;
    import tensil_mem_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req_valid, i_req_write, i_wr_valid, i_rsp_ready;
    logic [5:0]   i_req_addr;
    logic [7:0]   i_req_len;
    logic [127:0] i_wr_data;
    logic         o_req_ready, o_wr_ready, o_rsp_valid, o_rsp_last, o_busy;
    logic         o_mem_en, o_mem_we;
    logic [5:0]   o_mem_addr;
    logic [127:0] o_rsp_data, o_mem_di;
    logic [127:0] mem_do;
`ifdef BRAM_SEQ_STATS_EN
    logic [31:0]  stat_rd, stat_wr;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic init_mem = 1'b1;

    logic [127:0] bram [64];

    int        wr_addr_q[$];
    logic [127:0] wr_data_q[$];
    int        wr_cyc_q[$];
    int        rd_addr_q[$];
    int        rd_cyc_q[$];
    rsp_beat_t rsp_q[$];
    int        rsp_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_port_sequencer dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_len   (i_req_len),
        .i_wr_valid  (i_wr_valid),
        .o_wr_ready  (o_wr_ready),
        .i_wr_data   (i_wr_data),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_last  (o_rsp_last),
        .o_busy      (o_busy),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_di    (o_mem_di),
        .i_mem_do    (mem_do)
`ifdef BRAM_SEQ_STATS_EN
        ,
        .o_stat_rd_beats (stat_rd),
        .o_stat_wr_beats (stat_wr)
`endif
    );

    // BRAM with 1-cycle read latency; preloaded with 0x1000 + address.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) bram[i] <= 128'h1000 + 128'(i);
        end else if (o_mem_en) begin
            if (o_mem_we) bram[o_mem_addr] <= o_mem_di;
            else          mem_do <= bram[o_mem_addr];
        end
    end

    always @(negedge clk) begin
        if (o_mem_en && o_mem_we) begin
            wr_addr_q.push_back(int'(o_mem_addr));
            wr_data_q.push_back(o_mem_di);
            wr_cyc_q.push_back(cyc);
        end
        if (o_mem_en && !o_mem_we) begin
            rd_addr_q.push_back(int'(o_mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (o_rsp_valid && i_rsp_ready) begin
            rsp_q.push_back('{data: o_rsp_data, last: o_rsp_last});
            rsp_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        rsp_q.delete(); rsp_cyc_q.delete();
    endtask

    task automatic drive_req(input logic wr, input logic [5:0] addr, input logic [7:0] len);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_len   = len;
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [6:0] got;
        reset = 1'b1;
        i_req_valid = 0; i_req_write = 0; i_req_addr = 0; i_req_len = 0;
        i_wr_valid = 0; i_wr_data = 0; i_rsp_ready = 0;
        tick(); tick();
        init_mem = 1'b0;
        reset = 1'b0;
        got = {o_req_ready, o_wr_ready, o_rsp_valid, o_rsp_last, o_busy, o_mem_en, o_mem_we};
        n_vec++;
        if (got !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 1000000", got);
        end
        n_vec++;
        if (o_mem_addr !== 6'd0) begin
            n_err++;
            $display("FAIL reset_mem_addr: got %0d expected 0", o_mem_addr);
        end
    endtask

    task automatic test_write_read();
        int beats = 0;
        int k = 0;
        bit took, ok;
        clear_logs();
        drive_req(1'b1, 6'd5, 8'd3);
        i_wr_valid = 1'b1;
        i_wr_data  = 128'hA0;
        while (beats < 4 && k < 50) begin
            @(negedge clk);
            took = o_wr_ready;
            tick();
            k++;
            if (took) beats++;
            i_wr_data = 128'hA0 + 128'(beats);
        end
        i_wr_valid = 1'b0;
        n_vec++;
        if (wr_addr_q.size() != 4) begin
            n_err++;
            $display("FAIL wr_count: got %0d expected 4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (wr_addr_q[i] != 5 + i || wr_data_q[i] !== 128'hA0 + 128'(i) ||
                    wr_cyc_q[i] != wr_cyc_q[0] + i) begin
                    n_err++;
                    $display("FAIL wr_beat%0d: got addr %0d data %0h cyc+%0d expected addr %0d data %0h cyc+%0d",
                             i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - wr_cyc_q[0], 5 + i, 8'hA0 + i, i);
                end
            end
        end
        clear_logs();
        i_rsp_ready = 1'b1;
        drive_req(1'b0, 6'd5, 8'd3);
        wait_idle(50, ok);
        n_vec++;
        if (!ok || rsp_q.size() != 4) begin
            n_err++;
            $display("FAIL rd_back_count: got %0d beats (idle %0d) expected 4", rsp_q.size(), ok);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (rsp_q[i].data !== 128'hA0 + 128'(i) || rsp_q[i].last !== (i == 3)) begin
                    n_err++;
                    $display("FAIL rd_back_beat%0d: got %0h last %b expected %0h last %b",
                             i, rsp_q[i].data, rsp_q[i].last, 8'hA0 + i, (i == 3));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_addr[4] = '{62, 63, 0, 1};
        bit ok;
        clear_logs();
        i_rsp_ready = 1'b1;
        drive_req(1'b0, 6'd62, 8'd3);
        wait_idle(50, ok);
        n_vec++;
        if (!ok || rd_addr_q.size() != 4 || rsp_q.size() != 4) begin
            n_err++;
            $display("FAIL wrap_count: got %0d issues %0d beats (idle %0d) expected 4 4",
                     rd_addr_q.size(), rsp_q.size(), ok);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (rd_addr_q[i] != exp_addr[i] || rd_cyc_q[i] != rd_cyc_q[0] + i ||
                    rsp_q[i].data !== 128'h1000 + 128'(exp_addr[i]) ||
                    rsp_cyc_q[i] != rsp_cyc_q[0] + i || rsp_q[i].last !== (i == 3)) begin
                    n_err++;
                    $display("FAIL wrap_beat%0d: got addr %0d data %0h last %b expected addr %0d data %0h last %b",
                             i, rd_addr_q[i], rsp_q[i].data, rsp_q[i].last,
                             exp_addr[i], 16'h1000 + exp_addr[i], (i == 3));
                end
            end
            n_vec++;
            if (rsp_cyc_q[0] - rd_cyc_q[0] != 2) begin
                n_err++;
                $display("FAIL wrap_latency: got %0d cycles expected 2", rsp_cyc_q[0] - rd_cyc_q[0]);
            end
        end
`ifdef BRAM_SEQ_STATS_EN
        n_vec++;
        if (stat_wr !== 32'd4 || stat_rd !== 32'd8) begin
            n_err++;
            $display("FAIL stats: got wr %0d rd %0d expected wr 4 rd 8", stat_wr, stat_rd);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        i_rsp_ready = 1'b0;
        drive_req(1'b0, 6'd10, 8'd15);
        repeat (12) tick();
        n_vec++;
        if (rd_addr_q.size() != 4) begin
            n_err++;
            $display("FAIL stall_issues: got %0d expected 4", rd_addr_q.size());
        end
        n_vec++;
        if (o_rsp_valid !== 1'b1 || o_rsp_data !== 128'h100A || o_rsp_last !== 1'b0) begin
            n_err++;
            $display("FAIL stall_head: got valid %b data %0h last %b expected 1 100a 0",
                     o_rsp_valid, o_rsp_data, o_rsp_last);
        end
        repeat (3) tick();
        n_vec++;
        if (rd_addr_q.size() != 4 || o_rsp_data !== 128'h100A) begin
            n_err++;
            $display("FAIL stall_hold: got %0d issues data %0h expected 4 issues data 100a",
                     rd_addr_q.size(), o_rsp_data);
        end
        i_rsp_ready = 1'b1;
        wait_idle(100, ok);
        n_vec++;
        if (!ok || rsp_q.size() != 16 || rd_addr_q.size() != 16) begin
            n_err++;
            $display("FAIL stall_drain_count: got %0d beats %0d issues (idle %0d) expected 16 16",
                     rsp_q.size(), rd_addr_q.size(), ok);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_vec++;
                if (rsp_q[i].data !== 128'h100A + 128'(i) || rsp_q[i].last !== (i == 15)) begin
                    n_err++;
                    $display("FAIL stall_beat%0d: got %0h last %b expected %0h last %b",
                             i, rsp_q[i].data, rsp_q[i].last, 16'h100A + i, (i == 15));
                end
            end
        end
    endtask

    task automatic test_write_toggle();
        int beats = 0;
        int k = 0;
        bit took;
        clear_logs();
        drive_req(1'b1, 6'd40, 8'd3);
        i_wr_valid = 1'b1;
        i_wr_data  = 128'hB0;
        while (beats < 4 && k < 50) begin
            @(negedge clk);
            took = o_wr_ready;
            if (took && beats == 3) begin
                n_vec++;
                if (o_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL toggle_busy_last: got %b expected 1", o_busy);
                end
            end
            tick();
            k++;
            if (took) beats++;
            i_wr_valid = (k % 2 == 0);
            i_wr_data  = 128'hB0 + 128'(beats);
        end
        i_wr_valid = 1'b0;
        n_vec++;
        if (o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_done: got busy %b req_ready %b expected 0 1", o_busy, o_req_ready);
        end
        n_vec++;
        if (wr_addr_q.size() != 4) begin
            n_err++;
            $display("FAIL toggle_count: got %0d expected 4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (wr_addr_q[i] != 40 + i || wr_data_q[i] !== 128'hB0 + 128'(i) ||
                    wr_cyc_q[i] != wr_cyc_q[0] + 2 * i) begin
                    n_err++;
                    $display("FAIL toggle_beat%0d: got addr %0d data %0h cyc+%0d expected addr %0d data %0h cyc+%0d",
                             i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - wr_cyc_q[0], 40 + i, 8'hB0 + i, 2 * i);
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        int k = 0;
        bit ok;
        clear_logs();
        i_rsp_ready = 1'b0;
        drive_req(1'b0, 6'd20, 8'd7);
        while (rd_addr_q.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state: got rsp_valid %b busy %b req_ready %b expected 0 0 1",
                     o_rsp_valid, o_busy, o_req_ready);
        end
        tick();
        n_vec++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_discard: got rsp_valid %b busy %b expected 0 0", o_rsp_valid, o_busy);
        end
        clear_logs();
        i_rsp_ready = 1'b1;
        drive_req(1'b0, 6'd30, 8'd0);
        wait_idle(50, ok);
        n_vec++;
        if (!ok || rsp_q.size() != 1) begin
            n_err++;
            $display("FAIL single_count: got %0d beats (idle %0d) expected 1", rsp_q.size(), ok);
        end else begin
            n_vec++;
            if (rsp_q[0].data !== 128'h101E || rsp_q[0].last !== 1'b1) begin
                n_err++;
                $display("FAIL single_beat: got %0h last %b expected 101e last 1",
                         rsp_q[0].data, rsp_q[0].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_backpressure();
        test_write_toggle();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
